// File: rtl/traffic_light_fsm.sv
// Two-road intersection sequencer driving traffic_timer via done_pulse counts.
// Optional walk-lamp phase is compiled in with `define TLC_PED_WALK_EN.
module traffic_light_fsm #(
  parameter int GREEN_PULSES  = 2,
  parameter int YELLOW_PULSES = 1,
  parameter int ALLRED_PULSES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       done_pulse,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       timer_select,
  output logic       timer_restart,
  output logic       ped_walk,
  output logic [2:0] state_dbg
);

  localparam int MAX_GY = (GREEN_PULSES > YELLOW_PULSES) ?
                          GREEN_PULSES : YELLOW_PULSES;
  localparam int MAXP   = (MAX_GY > ALLRED_PULSES) ?
                          MAX_GY : ALLRED_PULSES;
  localparam int CW     = $clog2(MAXP) + 1;
  localparam int CW1    = CW + 1;

  localparam logic [CW:0] G_T = CW1'(GREEN_PULSES);
  localparam logic [CW:0] Y_T = CW1'(YELLOW_PULSES);
  localparam logic [CW:0] A_T = CW1'(ALLRED_PULSES);

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [CW:0]   cnt_inc;
  logic [CW:0]   ew_tgt;
  logic          inc;
  logic          enter;
  logic          enter_ewg;
  logic          req_any;
  logic          ew_pend;
  logic          ped_pend;

  // {ns_light, ew_light} for a given state; unknown codes show all red
  function automatic logic [5:0] lamps(input state_t s);
    case (s)
      NS_GREEN:  lamps = 6'b001_100;
      NS_YELLOW: lamps = 6'b010_100;
      EW_GREEN:  lamps = 6'b100_001;
      EW_YELLOW: lamps = 6'b100_010;
      default:   lamps = 6'b100_100;
    endcase
  endfunction

  assign state_dbg = state;

  // Pulse counting, request merge and next-state selection
  always_comb begin
    inc        = done_pulse & ~timer_restart;
    cnt_inc    = {1'b0, cnt} + {{CW{1'b0}}, inc};
    req_any    = ew_pend | ped_pend | ew_car | ped_req;
`ifdef TLC_PED_WALK_EN
    ew_tgt     = ped_walk ? (G_T + CW1'(1)) : G_T;
`else
    ew_tgt     = G_T;
`endif
    next_state = state;
    case (state)
      ALLRED_A:  if (cnt_inc >= A_T) next_state = NS_GREEN;
      NS_GREEN:  if (cnt_inc >= G_T && req_any) next_state = NS_YELLOW;
      NS_YELLOW: if (cnt_inc >= Y_T) next_state = ALLRED_B;
      ALLRED_B:  if (cnt_inc >= A_T) next_state = EW_GREEN;
      EW_GREEN:  if (cnt_inc >= ew_tgt) next_state = EW_YELLOW;
      EW_YELLOW: if (cnt_inc >= Y_T) next_state = ALLRED_A;
      default:   next_state = ALLRED_A;
    endcase
    enter     = (next_state != state);
    enter_ewg = enter && (next_state == EW_GREEN);
    if (enter)
      cnt_next = '0;
    else if (state == NS_GREEN && cnt_inc > G_T)
      cnt_next = G_T[CW-1:0];
    else
      cnt_next = cnt_inc[CW-1:0];
  end

  // State, counter, pending latches and registered lamp/timer outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ALLRED_A;
      cnt           <= '0;
      ns_light      <= 3'b100;
      ew_light      <= 3'b100;
      timer_select  <= 1'b0;
      timer_restart <= 1'b0;
      ew_pend       <= 1'b0;
      ped_pend      <= 1'b0;
    end else begin
      state                  <= next_state;
      cnt                    <= cnt_next;
      {ns_light, ew_light}   <= lamps(next_state);
      timer_select           <= (next_state == NS_GREEN) ||
                                (next_state == EW_GREEN);
      timer_restart          <= enter;
      if (enter_ewg)   ew_pend <= 1'b0;
      else if (ew_car) ew_pend <= 1'b1;
      if (enter_ewg)    ped_pend <= 1'b0;
      else if (ped_req) ped_pend <= 1'b1;
    end
  end

`ifdef TLC_PED_WALK_EN
  // Walk lamp granted for the whole EW green when a ped request was latched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ped_walk <= 1'b0;
    else if (next_state != EW_GREEN)
      ped_walk <= 1'b0;
    else if (enter_ewg)
      ped_walk <= ped_pend;
  end
`else
  assign ped_walk = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm (defaults 2/1/1).
// Walk checks follow TLC_PED_WALK_EN when defined.
module tb_traffic_light_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       done_pulse = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       timer_select;
  logic       timer_restart;
  logic       ped_walk;
  logic [2:0] state_dbg;

  int vecs = 0;
  int errs = 0;

  traffic_light_fsm dut (
    .clk           (clk),
    .rst           (rst),
    .done_pulse    (done_pulse),
    .ew_car        (ew_car),
    .ped_req       (ped_req),
    .ns_light      (ns_light),
    .ew_light      (ew_light),
    .timer_select  (timer_select),
    .timer_restart (timer_restart),
    .ped_walk      (ped_walk),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] got,
                     input logic [2:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse();
    step();
    done_pulse = 1'b1;
    step();
    done_pulse = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      vecs++;
      assert (!(ns_light[0] && ew_light[0])) else begin
        errs++;
        $error("FAIL both_green got %b/%b exp not both green",
               ns_light, ew_light);
      end
    end
  end

  initial begin
    step();
    step();
    chk("rst_ns", ns_light, 3'b100);
    chk("rst_ew", ew_light, 3'b100);
    chk("rst_sel", {2'b0, timer_select}, 3'd0);
    chk("rst_rs", {2'b0, timer_restart}, 3'd0);
    chk("rst_walk", {2'b0, ped_walk}, 3'd0);
    chk("rst_st", state_dbg, 3'd0);

    rst = 1'b1;
    step();
    chk("idle_a", state_dbg, 3'd0);
    pulse();
    chk("nsg_st", state_dbg, 3'd1);
    chk("nsg_ns", ns_light, 3'b001);
    chk("nsg_ew", ew_light, 3'b100);
    chk("nsg_sel", {2'b0, timer_select}, 3'd1);
    chk("nsg_rs", {2'b0, timer_restart}, 3'd1);
    step();
    chk("nsg_rs0", {2'b0, timer_restart}, 3'd0);

    for (int i = 0; i < 5; i++) begin
      pulse();
      chk("hold_st", state_dbg, 3'd1);
      chk("hold_ns", ns_light, 3'b001);
      chk("hold_rs", {2'b0, timer_restart}, 3'd0);
    end

    ew_car = 1'b1;
    step();
    ew_car = 1'b0;
    chk("nsy_st", state_dbg, 3'd2);
    chk("nsy_ns", ns_light, 3'b010);
    chk("nsy_sel", {2'b0, timer_select}, 3'd0);
    chk("nsy_rs", {2'b0, timer_restart}, 3'd1);

    done_pulse = 1'b1;
    step();
    done_pulse = 1'b0;
    chk("coinc_st", state_dbg, 3'd2);
    chk("coinc_rs", {2'b0, timer_restart}, 3'd0);

    pulse();
    chk("arb_st", state_dbg, 3'd3);
    chk("arb_ns", ns_light, 3'b100);
    chk("arb_ew", ew_light, 3'b100);
    pulse();
    chk("ewg_st", state_dbg, 3'd4);
    chk("ewg_ew", ew_light, 3'b001);
    chk("ewg_ns", ns_light, 3'b100);
    chk("ewg_sel", {2'b0, timer_select}, 3'd1);
    chk("ewg_walk", {2'b0, ped_walk}, 3'd0);
    pulse();
    chk("ewg1_st", state_dbg, 3'd4);
    pulse();
    chk("ewy_st", state_dbg, 3'd5);
    chk("ewy_ew", ew_light, 3'b010);
    chk("ewy_sel", {2'b0, timer_select}, 3'd0);
    pulse();
    chk("ara_st", state_dbg, 3'd0);
    chk("ara_ew", ew_light, 3'b100);
    pulse();
    chk("ns2_st", state_dbg, 3'd1);

    step();
    ew_car = 1'b1;
    step();
    ew_car = 1'b0;
    chk("early_st", state_dbg, 3'd1);
    pulse();
    chk("min1_st", state_dbg, 3'd1);
    pulse();
    chk("min2_st", state_dbg, 3'd2);
    pulse();
    chk("c2_arb", state_dbg, 3'd3);
    pulse();
    chk("c2_ewg", state_dbg, 3'd4);

    step();
    rst = 1'b0;
    #2;
    chk("arst_ns", ns_light, 3'b100);
    chk("arst_ew", ew_light, 3'b100);
    chk("arst_st", state_dbg, 3'd0);
    chk("arst_sel", {2'b0, timer_select}, 3'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pulse();
    chk("post_st", state_dbg, 3'd1);
    for (int i = 0; i < 3; i++) begin
      pulse();
      chk("nopend_st", state_dbg, 3'd1);
    end

    step();
    ped_req = 1'b1;
    done_pulse = 1'b1;
    step();
    ped_req = 1'b0;
    done_pulse = 1'b0;
    chk("ped_nsy", state_dbg, 3'd2);
    pulse();
    chk("ped_arb", state_dbg, 3'd3);
    pulse();
    chk("ped_ewg", state_dbg, 3'd4);
`ifdef TLC_PED_WALK_EN
    chk("walk_on", {2'b0, ped_walk}, 3'd1);
`else
    chk("walk_off", {2'b0, ped_walk}, 3'd0);
`endif
    ew_car = 1'b1;
    step();
    ew_car = 1'b0;
    pulse();
    chk("pg1_st", state_dbg, 3'd4);
`ifdef TLC_PED_WALK_EN
    chk("pg1_walk", {2'b0, ped_walk}, 3'd1);
    pulse();
    chk("pg2_st", state_dbg, 3'd4);
    chk("pg2_walk", {2'b0, ped_walk}, 3'd1);
    pulse();
    chk("pg3_st", state_dbg, 3'd5);
    chk("pg3_walk", {2'b0, ped_walk}, 3'd0);
`else
    pulse();
    chk("pg2_st", state_dbg, 3'd5);
    chk("pg2_walk", {2'b0, ped_walk}, 3'd0);
`endif
    pulse();
    chk("pa_st", state_dbg, 3'd0);
    pulse();
    chk("pn_st", state_dbg, 3'd1);
    pulse();
    chk("held1_st", state_dbg, 3'd1);
    pulse();
    chk("held2_st", state_dbg, 3'd2);
    chk("held2_ns", ns_light, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Sequencing controller for a two-road intersection: main road north/south (NS), side road east/west (EW).
- Drives `traffic_timer` through `timer_select` and a restart strobe, and counts its `done_pulse` outputs to time each phase.
- Holds NS green until a side-road car or pedestrian request is pending; then runs a full EW cycle and returns to NS.
- Sits between sensor/button inputs and the lamp drivers.

Parameters:
- GREEN_PULSES, default 2: long-timer `done_pulse`s for minimum NS green and for fixed EW green; must be ≥1.
- YELLOW_PULSES, default 1: short-timer `done_pulse`s for each yellow phase; must be ≥1.
- ALLRED_PULSES, default 1: short-timer `done_pulse`s for each all-red clearance phase; must be ≥1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- done_pulse  in  1  one-cycle completion pulse from `traffic_timer`.
- ew_car  in  1  side-road vehicle sensor, level.
- ped_req  in  1  pedestrian button, level or pulse.
- ns_light  out  3  {red,yellow,green} one-hot, registered.
- ew_light  out  3  {red,yellow,green} one-hot, registered.
- timer_select  out  1  0 = short interval, 1 = long interval; registered.
- timer_restart  out  1  one-cycle strobe on every phase entry; timer reloads.
- ped_walk  out  1  walk lamp; registered.
- state_dbg  out  3  current state encoding, for debug.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to ALLRED_A.
  - Outputs: ns_light=3'b100, ew_light=3'b100, timer_select=0, timer_restart=0, ped_walk=0.
  - Pulse counter cleared; pending latches cleared.
  - Reset mid-phase aborts that phase immediately.
- States, with timer_select and exit condition:
  - ALLRED_A (0): ALLRED_PULSES pulses → NS_GREEN.
  - NS_GREEN (1): count ≥ GREEN_PULSES and (ew_pend or ped_pend) → NS_YELLOW. Otherwise stay; counter saturates at GREEN_PULSES.
  - NS_YELLOW (0): YELLOW_PULSES pulses → ALLRED_B.
  - ALLRED_B (0): ALLRED_PULSES pulses → EW_GREEN.
  - EW_GREEN (1): exactly GREEN_PULSES pulses, no extension → EW_YELLOW.
  - EW_YELLOW (0): YELLOW_PULSES pulses → ALLRED_A.
- Lights:
  - Lamp on the active road follows the state: green, yellow or red.
  - The other road is red.
  - Both roads are red in ALLRED_A/B.
  - Never green on both roads, in any cycle.
- Timing:
  - Exit is taken on the edge that samples the completing `done_pulse`.
  - New light, new timer_select and timer_restart=1 are visible the following cycle (1-cycle latency).
- Pulse counter:
  - Cleared on phase entry.
  - Increments on `done_pulse` only when timer_restart=0; a `done_pulse` coincident with timer_restart is ignored.
  - Width is $clog2(max parameter)+1.
- Pending latches:
  - ew_pend and ped_pend are sticky, set when ew_car or ped_req is high.
  - Both are cleared on entry to EW_GREEN; set wins over clear in the same cycle only when the state is not entering EW_GREEN.
  - A request arriving during EW_GREEN/EW_YELLOW/ALLRED_A is held for the next NS_GREEN.
  - In NS_GREEN, a request and the final counted pulse in the same cycle: the request is honoured on that edge.
- Unused state encodings recover to ALLRED_A on the next edge.

Optional Feature:
- Macro: TLC_PED_WALK_EN.
- Defined:
  - ped_pend sampled at EW_GREEN entry sets ped_walk=1 for all of EW_GREEN.
  - ped_walk is cleared on EW_YELLOW entry.
  - When walk is granted, the EW_GREEN length is GREEN_PULSES+1 pulses.
- Undefined:
  - ped_req only acts as a side-road request.
  - ped_walk is tied 0.
  - EW_GREEN is always GREEN_PULSES pulses.

Test Plan (defaults: GREEN 2, YELLOW 1, ALLRED 1):
- Reset release, then 1 done_pulse → ns_light=001, timer_select=1, timer_restart=1 for one cycle, state NS_GREEN.
- No requests, 5 done_pulses in NS_GREEN → stays NS_GREEN with ns_light=001; no timer_restart after the entry strobe.
- ew_car 1-cycle pulse before min green, then 2 pulses → NS_YELLOW (010) next cycle. After 1 pulse: ALLRED_B (100/100). After 1 pulse: EW_GREEN (ew_light=001). After 2 pulses: EW_YELLOW. After 1 pulse: ALLRED_A.
- done_pulse coincident with timer_restart → counter unchanged; NS_YELLOW lasts until a later pulse.
- rst=0 asserted asynchronously mid-EW_GREEN → lights 100/100 immediately without a clock edge; ew_pend cleared.
- With TLC_PED_WALK_EN: ped_req during NS_GREEN → ped_walk=1 throughout EW_GREEN; EW_GREEN takes 3 pulses; ped_walk=0 on EW_YELLOW entry. Without the macro: ped_walk stays 0.
